nonce_scheduler: RTL and testbench

Control stage directly upstream of the `Sha256` compression core: scans a nonce range by driving the core twice per nonce (header tail over a precomputed midstate, then the digest of that pass). It compares the final double-SHA256 against a 256-bit target and reports the first winning nonce. It owns the core's `valid`/`load_init`/`init_*`/`chunk_*` inputs and consumes its `ready` and `hash_*` outputs.

---
 rtl/nonce_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_nonce_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_scheduler.sv
// Bitcoin nonce scanner: drives an upstream SHA256 compression core twice per
// nonce (header tail over midstate, then digest) and reports the first hit.
module nonce_scheduler (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         start,
    input  logic         stop,
    input  logic [255:0] midstate,
    input  logic [31:0]  merkle_tail,
    input  logic [31:0]  ntime,
    input  logic [31:0]  nbits,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic [255:0] target,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [31:0]  found_nonce,
    output logic [31:0]  hash_count,
    output logic         core_valid,
    output logic         core_load_init,
    input  logic         core_ready,
    output logic [255:0] core_init,
    output logic [511:0] core_chunk,
    input  logic [255:0] core_hash
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE1, S_WAIT1, S_ISSUE2, S_WAIT2, S_CHECK
    } state_t;

    localparam logic [255:0] SHA_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    state_t       state_q, state_d;
    logic [31:0]  nonce_q, nonce_d;
    logic [31:0]  end_q, end_d;
    logic [255:0] target_q, target_d;
    logic [255:0] mid_q, mid_d;
    logic [31:0]  mt_q, mt_d, nt_q, nt_d, nb_q, nb_d;
    logic [255:0] digest1_q, digest1_d;
    logic         done_q, done_d, found_q, found_d;
    logic [31:0]  fnonce_q, fnonce_d, count_q, count_d;
    logic [255:0] init_q, init_d;
    logic [511:0] chunk_q, chunk_d;

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Header words 16..19 plus SHA padding for an 80-byte message.
    function automatic logic [511:0] pass1_chunk(input logic [31:0] mt, input logic [31:0] nt,
                                                 input logic [31:0] nb, input logic [31:0] nonce);
        return {mt, nt, nb, bswap32(nonce), 32'h80000000, 320'd0, 32'h00000280};
    endfunction

    function automatic logic [511:0] pass2_chunk(input logic [255:0] d);
        return {d, 32'h80000000, 192'd0, 32'h00000100};
    endfunction

    // Digest as the little-endian 256-bit number Bitcoin compares against the target.
    function automatic logic [255:0] hash_value(input logic [255:0] h);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[255-32*i -: 32] = bswap32(h[32*i +: 32]);
        end
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        nonce_d   = nonce_q;
        end_d     = end_q;
        target_d  = target_q;
        mid_d     = mid_q;
        mt_d      = mt_q;
        nt_d      = nt_q;
        nb_d      = nb_q;
        digest1_d = digest1_q;
        done_d    = done_q;
        found_d   = found_q;
        fnonce_d  = fnonce_q;
        count_d   = count_q;
        init_d    = init_q;
        chunk_d   = chunk_q;

        if (stop && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && !stop) begin
                        nonce_d  = nonce_start;
                        end_d    = nonce_end;
                        target_d = target;
                        mid_d    = midstate;
                        mt_d     = merkle_tail;
                        nt_d     = ntime;
                        nb_d     = nbits;
                        done_d   = 1'b0;
                        found_d  = 1'b0;
                        fnonce_d = '0;
                        count_d  = '0;
                        init_d   = midstate;
                        chunk_d  = pass1_chunk(merkle_tail, ntime, nbits, nonce_start);
                        state_d  = S_ISSUE1;
                    end
                end
                S_ISSUE1: if (core_ready) state_d = S_WAIT1;
                S_WAIT1: begin
                    if (core_ready) begin
                        digest1_d = core_hash;
                        init_d    = SHA_IV;
                        chunk_d   = pass2_chunk(core_hash);
                        state_d   = S_ISSUE2;
                    end
                end
                S_ISSUE2: if (core_ready) state_d = S_WAIT2;
                S_WAIT2:  if (core_ready) state_d = S_CHECK;
                S_CHECK: begin
                    count_d = count_q + 32'd1;
                    if (hash_value(core_hash) <= target_q) begin
                        found_d  = 1'b1;
                        fnonce_d = nonce_q;
                        done_d   = 1'b1;
                        state_d  = S_IDLE;
                    end else if (nonce_q == end_q) begin
                        done_d  = 1'b1;
                        found_d = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        nonce_d = nonce_q + 32'd1;
                        init_d  = mid_q;
                        chunk_d = pass1_chunk(mt_q, nt_q, nb_q, nonce_q + 32'd1);
                        state_d = S_ISSUE1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= S_IDLE;
            nonce_q   <= '0;
            end_q     <= '0;
            target_q  <= '0;
            mid_q     <= '0;
            mt_q      <= '0;
            nt_q      <= '0;
            nb_q      <= '0;
            digest1_q <= '0;
            done_q    <= 1'b0;
            found_q   <= 1'b0;
            fnonce_q  <= '0;
            count_q   <= '0;
            init_q    <= '0;
            chunk_q   <= '0;
        end else begin
            state_q   <= state_d;
            nonce_q   <= nonce_d;
            end_q     <= end_d;
            target_q  <= target_d;
            mid_q     <= mid_d;
            mt_q      <= mt_d;
            nt_q      <= nt_d;
            nb_q      <= nb_d;
            digest1_q <= digest1_d;
            done_q    <= done_d;
            found_q   <= found_d;
            fnonce_q  <= fnonce_d;
            count_q   <= count_d;
            init_q    <= init_d;
            chunk_q   <= chunk_d;
        end
    end

    // Valid is gated by ready so a job left running by a stop is never overrun.
    assign core_valid     = (state_q == S_ISSUE1 || state_q == S_ISSUE2) && core_ready;
    assign core_load_init = 1'b1;
    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign found          = found_q;
    assign found_nonce    = fnonce_q;
    assign hash_count     = count_q;
    assign core_init      = init_q;
    assign core_chunk     = chunk_q;

endmodule

// File: tb/tb_nonce_scheduler.sv
// Bench for nonce_scheduler with a behavioural 66-cycle SHA256 core and a
// scoreboard of expected scan outcomes and pass-1 nonce words.
module tb_nonce_scheduler;

    logic         clk = 1'b0;
    logic         arst_n, start, stop;
    logic [255:0] midstate, target;
    logic [31:0]  merkle_tail, ntime, nbits, nonce_start, nonce_end;
    logic         busy, done, found, core_valid, core_load_init, core_ready;
    logic [31:0]  found_nonce, hash_count;
    logic [255:0] core_init, core_hash;
    logic [511:0] core_chunk;

    always #5 clk = ~clk;

    nonce_scheduler dut (
        .clk(clk), .arst_n(arst_n), .start(start), .stop(stop),
        .midstate(midstate), .merkle_tail(merkle_tail), .ntime(ntime), .nbits(nbits),
        .nonce_start(nonce_start), .nonce_end(nonce_end), .target(target),
        .busy(busy), .done(done), .found(found), .found_nonce(found_nonce),
        .hash_count(hash_count), .core_valid(core_valid), .core_load_init(core_load_init),
        .core_ready(core_ready), .core_init(core_init), .core_chunk(core_chunk),
        .core_hash(core_hash)
    );

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] st, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        {a, b, c, d, e, f, g, h} = st;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {st[255:224] + a, st[223:192] + b, st[191:160] + c, st[159:128] + d,
                st[127:96] + e, st[95:64] + f, st[63:32] + g, st[31:0] + h};
    endfunction

    // Core model: accepts at t, ready low t+1..t+65, ready and hash valid from t+66.
    logic [255:0] pend;
    int           busy_cnt;
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            core_ready <= 1'b1;
            core_hash  <= '0;
            busy_cnt   <= 0;
            pend       <= '0;
        end else if (core_ready && core_valid) begin
            core_ready <= 1'b0;
            busy_cnt   <= 65;
            pend       <= sha_compress(core_init, core_chunk);
        end else if (busy_cnt == 1) begin
            core_ready <= 1'b1;
            core_hash  <= pend;
            busy_cnt   <= 0;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic        f;
        logic [31:0] n;
        logic [31:0] c;
        int          rel;
    } exp_t;
    exp_t         sb[$];
    logic [31:0]  w3_q[$];
    logic [255:0] mid_exp;
    int           acc_cnt = 0;
    int           s0 = 0;

    // Pass-1 accepts are recognised by the 80-byte length word in chunk word 15.
    always @(negedge clk) begin
        if (arst_n && core_valid && core_ready) begin
            acc_cnt++;
            if (core_chunk[31:0] == 32'h00000280) begin
                check_val("w3_pending", 256'(w3_q.size() > 0), 256'(1));
                if (w3_q.size() > 0) check_val("chunk_w3", 256'(core_chunk[415:384]), 256'(w3_q.pop_front()));
                check_val("pass1_init", core_init, mid_exp);
                check_val("pass1_hdr", 256'(core_chunk[511:416]), 256'({merkle_tail, ntime, nbits}));
            end else begin
                check_val("pass2_init", core_init, IV);
                check_val("pass2_pad", 256'(core_chunk[255:0]), {32'h80000000, 192'd0, 32'h00000100});
            end
        end
    end

    task automatic drive_job(input logic [31:0] ns, input logic [31:0] ne, input logic [255:0] tgt);
        nonce_start = ns;
        nonce_end   = ne;
        target      = tgt;
        start       = 1'b1;
        s0          = int'(cyc);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic expect_job(input logic [31:0] ns, input int n, input logic f,
                              input logic [31:0] fn, input int rel);
        exp_t e;
        for (int i = 0; i < n; i++) w3_q.push_back(bswap(ns + 32'(i)));
        e.f = f; e.n = f ? fn : 32'd0; e.c = 32'(n); e.rel = rel;
        sb.push_back(e);
    endtask

    task automatic wait_and_score(input string tag);
        int   rel;
        exp_t e;
        rel = -1;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin
                rel = int'(cyc) - s0;
                break;
            end
            @(negedge clk);
        end
        e = sb.pop_front();
        check_val({tag, "_done_cycle"}, 256'(rel), 256'(e.rel));
        check_val({tag, "_found"}, 256'(found), 256'(e.f));
        check_val({tag, "_found_nonce"}, 256'(found_nonce), 256'(e.n));
        check_val({tag, "_hash_count"}, 256'(hash_count), 256'(e.c));
        check_val({tag, "_busy"}, 256'(busy), 256'(0));
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_busy"}, 256'(busy), 256'(0));
        check_val({tag, "_done"}, 256'(done), 256'(0));
        check_val({tag, "_found"}, 256'(found), 256'(0));
        check_val({tag, "_found_nonce"}, 256'(found_nonce), 256'(0));
        check_val({tag, "_hash_count"}, 256'(hash_count), 256'(0));
        check_val({tag, "_core_valid"}, 256'(core_valid), 256'(0));
        check_val({tag, "_core_load_init"}, 256'(core_load_init), 256'(1));
        check_val({tag, "_core_init"}, core_init, 256'(0));
        check_val({tag, "_core_chunk_hi"}, core_chunk[511:256], 256'(0));
        check_val({tag, "_core_chunk_lo"}, core_chunk[255:0], 256'(0));
    endtask

    localparam logic [255:0] GEN_TARGET = {32'h00000000, 32'hFFFF0000, 192'd0};

    initial begin
        int first_rel;
        int acc_before;
        arst_n = 1'b0; start = 1'b0; stop = 1'b0;
        merkle_tail = '0; ntime = '0; nbits = '0;
        nonce_start = '0; nonce_end = '0; target = '0; midstate = '0;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        arst_n = 1'b1;
        @(negedge clk);

        // Genesis block header: bytes 0..63 folded into the midstate here.
        midstate = sha_compress(IV, {32'h01000000, 256'd0,
            32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61,
            32'h7fc81bc3, 32'h888a5132, 32'h3a9fb8aa});
        mid_exp     = midstate;
        merkle_tail = 32'h4b1e5e4a;
        ntime       = 32'h29ab5f49;
        nbits       = 32'hffff001d;

        expect_job(32'h7C2BAC1B, 3, 1'b1, 32'h7C2BAC1D, 406);
        drive_job(32'h7C2BAC1B, 32'h7C2BAC20, GEN_TARGET);
        wait_and_score("genesis_hit");

        expect_job(32'h7C2BAC1E, 3, 1'b0, 32'h0, 406);
        drive_job(32'h7C2BAC1E, 32'h7C2BAC20, GEN_TARGET);
        wait_and_score("genesis_miss");

        expect_job(32'h12345678, 1, 1'b1, 32'h12345678, 136);
        drive_job(32'h12345678, 32'h12345678, '1);
        wait_and_score("single_ones");

        expect_job(32'hFFFFFFFE, 4, 1'b0, 32'h0, 541);
        drive_job(32'hFFFFFFFE, 32'h00000001, '0);
        wait_and_score("wrap");

        // Stop at 40, restart at 42: the restart must wait for the abandoned job.
        w3_q.push_back(bswap(32'h00000000));
        drive_job(32'h00000000, 32'h00000100, '0);
        repeat (39) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_val("stop_busy", 256'(busy), 256'(0));
        check_val("stop_done_hold", 256'(done), 256'(0));
        check_val("stop_count_hold", 256'(hash_count), 256'(0));
        @(negedge clk);
        first_rel = int'(cyc) - s0;
        check_val("restart_cycle", 256'(first_rel), 256'(42));
        expect_job(32'hABCD0001, 1, 1'b1, 32'hABCD0001, 160);
        drive_job(32'hABCD0001, 32'hABCD0001, '1);
        first_rel = -1;
        for (int i = 0; i < 200; i++) begin
            if (core_valid) begin
                first_rel = int'(cyc) - s0 + 42;
                break;
            end
            @(negedge clk);
        end
        check_val("restart_first_valid", 256'(first_rel), 256'(67));
        wait_and_score("restart");

        // Asynchronous reset in the middle of a scan.
        w3_q.push_back(bswap(32'h00000000));
        drive_job(32'h00000000, 32'h0000000A, '0);
        repeat (99) @(negedge clk);
        check_val("pre_reset_busy", 256'(busy), 256'(1));
        #1 arst_n = 1'b0;
        #1 check_reset_values("midreset");
        @(negedge clk);
        arst_n = 1'b1;
        acc_before = acc_cnt;
        repeat (300) @(negedge clk);
        check_val("post_reset_no_valid", 256'(acc_cnt), 256'(acc_before));
        check_val("post_reset_busy", 256'(busy), 256'(0));
        check_val("w3_queue_drained", 256'(w3_q.size()), 256'(0));
        check_val("sb_drained", 256'(sb.size()), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
